// File: rtl/activation_stream_collector_pkg.sv
// Shared definitions for the activation stream collector: default widths and
// the storage entry layout (frame-end tag above the signed sample).
package activation_stream_collector_pkg;

  localparam int DATA_W_DEF    = 22;
  localparam int FRAME_LEN_DEF = 64;
  localparam int DEPTH_DEF     = 16;

  typedef struct packed {
    logic                         last;
    logic signed [DATA_W_DEF-1:0] data;
  } entry_t;

  // Counter width that stays legal when the range collapses to a single value.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/activation_stream_collector_sync_fifo.sv
// First-word-fall-through FIFO: the head entry is driven straight from storage,
// so a sample written into an empty FIFO is visible right after its write edge.
module sync_fifo_fwft
  import activation_stream_collector_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEF,
  parameter type T_ENTRY = entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr,
  input  T_ENTRY                     i_wr_data,
  input  logic                       i_rd,
  output T_ENTRY                     o_rd_data,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T_ENTRY        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_rd;
  logic w_wr;
  logic w_full;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_rd   = i_rd & (r_count != '0);
  // A read in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_wr   = i_wr & (~w_full | w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_valid   = (r_count != '0);
  assign o_full    = w_full;
  assign o_count   = r_count;

endmodule

// File: rtl/activation_stream_collector.sv
// Collects the activation output stream into a FWFT FIFO, tags frame-final
// samples, and latches a sticky overflow flag when samples are dropped.
module activation_stream_collector
  import activation_stream_collector_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       out_valid,
  output logic signed [DATA_W-1:0]   out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int FW = clog2_min1(FRAME_LEN);

  typedef struct packed {
    logic                     last;
    logic signed [DATA_W-1:0] data;
  } entry_w_t;

  logic [FW-1:0] r_frame_pos;
  logic          r_overflow;

  entry_w_t w_wr_entry;
  entry_w_t w_rd_entry;
  logic     w_full;
  logic     w_last_tag;
  logic     w_read;
  logic     w_drop;

  assign w_last_tag = (r_frame_pos == FW'(FRAME_LEN-1));
  assign w_wr_entry = '{last: w_last_tag, data: in_data};
  assign w_read     = out_valid & out_ready;
  assign w_drop     = in_valid & w_full & ~w_read;

  sync_fifo_fwft #(
    .DEPTH   (DEPTH),
    .T_ENTRY (entry_w_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .i_wr      (in_valid),
    .i_wr_data (w_wr_entry),
    .i_rd      (out_ready),
    .o_rd_data (w_rd_entry),
    .o_valid   (out_valid),
    .o_full    (w_full),
    .o_count   (count)
  );

  // Position advances on every presented sample, dropped or not, so frame
  // boundaries stay aligned with the source even across overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_pos <= '0;
    end else if (in_valid) begin
      r_frame_pos <= w_last_tag ? '0 : r_frame_pos + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign out_data = w_rd_entry.data;
  assign out_last = w_rd_entry.last;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_activation_stream_collector.sv
// Randomized and directed bench for activation_stream_collector, checked
// against a queue-based reference model of the FIFO, frame tags and overflow.
module tb_activation_stream_collector;

  localparam int DW    = 22;
  localparam int DEPTH = 16;
  localparam int FL    = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clr_overflow;

  int n_chk = 0;
  int n_err = 0;

  logic [DW:0] m_q[$];
  int          m_pos;
  logic        m_ovf;

  activation_stream_collector #(
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] s2d(input int v);
    return v[DW-1:0];
  endfunction

  task automatic cmp_model();
    check_val("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    check_val("count", 64'(count), 64'(m_q.size()));
    check_val("overflow", 64'(overflow), 64'(m_ovf));
    if (m_q.size() != 0) begin
      check_val("out_data", 64'(out_data), 64'(m_q[0][DW-1:0]));
      check_val("out_last", 64'(out_last), 64'(m_q[0][DW]));
    end
  endtask

  // One clock of stimulus; the model applies the FIFO rules at the edge,
  // then outputs are compared 1 ns after that edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
    logic rd, wr, drop, last;
    @(negedge clk);
    in_valid     = v;
    in_data      = d;
    out_ready    = rdy;
    clr_overflow = clr;
    rd   = rdy && (m_q.size() > 0);
    wr   = v && ((m_q.size() < DEPTH) || rd);
    drop = v && !wr;
    last = (m_pos == FL-1);
    @(posedge clk);
    if (rd) void'(m_q.pop_front());
    if (wr) m_q.push_back({last, d});
    if (v) m_pos = (m_pos + 1) % FL;
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
    cmp_model();
  endtask

  // Reset asserted in the middle of the low clock phase; effect must be immediate.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("rst_out_valid", 64'(out_valid), 64'(0));
    check_val("rst_count", 64'(count), 64'(0));
    check_val("rst_overflow", 64'(overflow), 64'(0));
    m_q.delete();
    m_pos = 0;
    m_ovf = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int rdy_pct;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_overflow = 1'b0;
    m_pos = 0; m_ovf = 1'b0;
    do_reset();

    // Frame tagging: with FRAME_LEN=4, samples 3 and 7 of nine are frame ends.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, s2d(100 + i), 1'b1, 1'b0);
      check_val("frame_last", 64'(out_last), 64'((i == 3) || (i == 7)));
    end
    step(1'b0, '0, 1'b1, 1'b0);

    // Pass-through with one-cycle latency and no sign mangling.
    step(1'b1, s2d(-5), 1'b1, 1'b0);
    check_val("pass_m5", 64'(out_data), 64'(s2d(-5)));
    check_val("pass_cnt", 64'(count), 64'(1));
    step(1'b1, s2d(7), 1'b1, 1'b0);
    check_val("pass_7", 64'(out_data), 64'(s2d(7)));
    check_val("pass_cnt", 64'(count), 64'(1));
    step(1'b1, s2d(0), 1'b1, 1'b0);
    check_val("pass_0", 64'(out_data), 64'(s2d(0)));
    check_val("pass_cnt", 64'(count), 64'(1));
    step(1'b0, '0, 1'b1, 1'b0);

    // Overflow: 18 samples into 16 slots, last two dropped.
    do_reset();
    for (int i = 0; i < 18; i++) step(1'b1, s2d(i), 1'b0, 1'b0);
    check_val("ovf_count", 64'(count), 64'(16));
    check_val("ovf_flag", 64'(overflow), 64'(1));
    for (int i = 0; i < 16; i++) begin
      check_val("drain_data", 64'(out_data), 64'(s2d(i)));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    check_val("drain_empty", 64'(count), 64'(0));

    // Full with concurrent read/write: occupancy holds, nothing dropped.
    step(1'b0, '0, 1'b0, 1'b1);
    check_val("ovf_cleared", 64'(overflow), 64'(0));
    for (int i = 0; i < 16; i++) step(1'b1, s2d(200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, s2d(300 + i), 1'b1, 1'b0);
      check_val("full_rw_count", 64'(count), 64'(16));
      check_val("full_rw_ovf", 64'(overflow), 64'(0));
      check_val("full_rw_head", 64'(out_data), 64'(s2d(201 + i)));
    end

    // Drop beats clear in the same cycle; clear alone then wins.
    step(1'b1, s2d(400), 1'b0, 1'b0);
    check_val("drop_sets", 64'(overflow), 64'(1));
    step(1'b1, s2d(401), 1'b0, 1'b1);
    check_val("drop_wins", 64'(overflow), 64'(1));
    step(1'b0, '0, 1'b0, 1'b1);
    check_val("clear_alone", 64'(overflow), 64'(0));

    // Mid-frame reset: count=5 at frame position 2, then a fresh frame.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, s2d(500 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_val("pre_rst_count", 64'(count), 64'(5));
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, s2d(600 + k), 1'b1, 1'b0);
      check_val("post_rst_last", 64'(out_last), 64'(k == 4));
    end

    // Random traffic with per-segment consumer throughput and rare resets.
    for (int seg = 0; seg < 15; seg++) begin
      rdy_pct = $urandom_range(10, 90);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 399) == 0) do_reset();
        step(($urandom_range(0, 99) < 70), $urandom(), ($urandom_range(0, 99) < rdy_pct),
             ($urandom_range(0, 99) < 5));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
